// File: rtl/rvm_control_seq.sv
// Main control sequencer for the multi-cycle core: fetch/decode/execute/mem/writeback, traps, irqs.
// Optional bus-timeout trap enabled by defining RVM_CTRL_TIMEOUT_EN.
module rvm_control_seq #(
  parameter int NIRQ           = 4,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic            imem_err,
  output logic            dmem_req,
  output logic            dmem_wen,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic            dmem_err,
  input  logic [2:0]      dec_op,
  output logic            md_start,
  input  logic            md_done,
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] irq_en,
  output logic            ir_we,
  output logic            pc_we,
  output logic            rf_we,
  output logic            trap_take,
  output logic [3:0]      trap_cause,
  output logic [3:0]      ctrl_state
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH_REQ  = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXECUTE    = 4'd4,
    S_MD_WAIT    = 4'd5,
    S_MEM_REQ    = 4'd6,
    S_MEM_WAIT   = 4'd7,
    S_WRITEBACK  = 4'd8,
    S_TRAP       = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_MULDIV = 3'd4,
    OP_SYSTEM = 3'd5,
    OP_ILL6   = 3'd6,
    OP_ILL7   = 3'd7
  } op_t;

  localparam logic [3:0] C_FETCH_ERR = 4'd1;
  localparam logic [3:0] C_ILLEGAL   = 4'd2;
  localparam logic [3:0] C_LOAD_ERR  = 4'd5;
  localparam logic [3:0] C_STORE_ERR = 4'd7;
  localparam logic [3:0] C_SYSTEM    = 4'd11;

  state_t          state;
  op_t             op_q;
  logic            req_issued_q;
  logic [NIRQ-1:0] irq_masked;
  logic            irq_pending;
  logic            irq_found;
  logic [2:0]      irq_idx;
  logic            tmo_hit;
  logic            is_store;
  logic [3:0]      mem_err_cause;

  assign irq_masked    = irq & irq_en;
  assign irq_pending   = |irq_masked;
  assign is_store      = (op_q == OP_STORE);
  assign mem_err_cause = is_store ? C_STORE_ERR : C_LOAD_ERR;
  assign ctrl_state    = state;

  always_comb begin
    irq_idx   = '0;
    irq_found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (irq_masked[i] && !irq_found) begin
        irq_idx   = 3'(i);
        irq_found = 1'b1;
      end
    end
  end

`ifdef RVM_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 wait_st;
  logic                 wait_done;

  always_comb begin
    wait_st   = 1'b1;
    wait_done = 1'b0;
    case (state)
      S_FETCH_REQ:  wait_done = imem_req && imem_gnt;
      S_FETCH_WAIT: wait_done = imem_rvalid;
      S_MEM_REQ:    wait_done = dmem_gnt;
      S_MEM_WAIT:   wait_done = dmem_rvalid;
      default:      wait_st   = 1'b0;
    endcase
  end

  // Counter runs across the req and wait phases of one transaction and saturates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
    end else if (!wait_st) begin
      tmo_cnt <= '0;
    end else if (!wait_done && (tmo_cnt != '1)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = wait_st && !wait_done &&
                   (tmo_cnt >= TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_RESET;
      op_q         <= OP_ALU;
      trap_cause   <= '0;
      req_issued_q <= 1'b0;
    end else begin
      case (state)
        S_RESET: state <= S_FETCH_REQ;

        S_FETCH_REQ: begin
          if (irq_pending && !req_issued_q) begin
            state      <= S_TRAP;
            trap_cause <= {1'b1, irq_idx};
          end else begin
            req_issued_q <= 1'b1;
            if (imem_gnt) begin
              if (imem_rvalid && imem_err) begin
                state      <= S_TRAP;
                trap_cause <= C_FETCH_ERR;
              end else if (imem_rvalid) begin
                state <= S_DECODE;
              end else begin
                state <= S_FETCH_WAIT;
              end
            end else if (tmo_hit) begin
              state      <= S_TRAP;
              trap_cause <= C_FETCH_ERR;
            end
          end
        end

        S_FETCH_WAIT: begin
          if (imem_rvalid && imem_err) begin
            state      <= S_TRAP;
            trap_cause <= C_FETCH_ERR;
          end else if (imem_rvalid) begin
            state <= S_DECODE;
          end else if (tmo_hit) begin
            state      <= S_TRAP;
            trap_cause <= C_FETCH_ERR;
          end
        end

        S_DECODE: begin
          op_q         <= op_t'(dec_op);
          req_issued_q <= 1'b0;
          if (dec_op[2:1] == 2'b11) begin
            state      <= S_TRAP;
            trap_cause <= C_ILLEGAL;
          end else if (op_t'(dec_op) == OP_SYSTEM) begin
            state      <= S_TRAP;
            trap_cause <= C_SYSTEM;
          end else begin
            state <= S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          case (op_q)
            OP_ALU:            state <= S_WRITEBACK;
            OP_BRANCH:         state <= S_FETCH_REQ;
            OP_LOAD, OP_STORE: state <= S_MEM_REQ;
            OP_MULDIV:         state <= S_MD_WAIT;
            default: begin
              state      <= S_TRAP;
              trap_cause <= C_ILLEGAL;
            end
          endcase
        end

        S_MD_WAIT: if (md_done) state <= S_WRITEBACK;

        S_MEM_REQ, S_MEM_WAIT: begin
          if ((state == S_MEM_WAIT || dmem_gnt) && dmem_rvalid) begin
            if (dmem_err) begin
              state      <= S_TRAP;
              trap_cause <= mem_err_cause;
            end else begin
              state <= is_store ? S_FETCH_REQ : S_WRITEBACK;
            end
          end else if (state == S_MEM_REQ && dmem_gnt) begin
            state <= S_MEM_WAIT;
          end else if (tmo_hit) begin
            state      <= S_TRAP;
            trap_cause <= mem_err_cause;
          end
        end

        S_WRITEBACK: state <= S_FETCH_REQ;

        // Clearing here lets the re-fetch after a fetch-side trap sample interrupts again.
        S_TRAP: begin
          state        <= S_FETCH_REQ;
          req_issued_q <= 1'b0;
        end

        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state == S_FETCH_REQ) && !(irq_pending && !req_issued_q);
    ir_we     = imem_rvalid && !imem_err &&
                ((state == S_FETCH_WAIT) || (imem_req && imem_gnt));
    dmem_req  = (state == S_MEM_REQ);
    dmem_wen  = dmem_req && is_store;
    md_start  = (state == S_EXECUTE) && (op_q == OP_MULDIV);
    rf_we     = (state == S_WRITEBACK);
    trap_take = (state == S_TRAP);
    pc_we     = (state == S_WRITEBACK) || (state == S_TRAP) ||
                ((state == S_EXECUTE) && (op_q == OP_BRANCH)) ||
                (is_store && dmem_rvalid && !dmem_err &&
                 ((state == S_MEM_WAIT) || ((state == S_MEM_REQ) && dmem_gnt)));
  end

endmodule
